// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM states, funct3 and fault codes.
package load_store_unit_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACC0  = 3'd1,
        S_WAIT0 = 3'd2,
        S_ACC1  = 3'd3,
        S_WAIT1 = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_FUNCT3   = 2'b10;

    // Stores have no unsigned variants, so only B/H/W are legal for them.
    function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3);
        if (is_store) begin
            return funct3 inside {F3_B, F3_H, F3_W};
        end
        return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store lane masks/data across two words, load lane merge and extension.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] word0,
    input  logic [31:0] word1,
    output logic [3:0]  mask0,
    output logic [3:0]  mask1,
    output logic [31:0] wdata0,
    output logic [31:0] wdata1,
    output logic [31:0] rdata
);

    logic [3:0]  size_mask;
    logic [7:0]  mask8;
    logic [63:0] lanes;
    logic [31:0] merged;
    logic [5:0]  shamt;

    always_comb begin
        shamt = {1'b0, offset, 3'b000};
        case (funct3[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase

        // Treat the two consecutive words as one 8-lane window; upper half is the second access.
        mask8 = {4'b0000, size_mask} << offset;
        lanes = {32'h0, wdata} << shamt;
        for (int i = 0; i < 8; i++) begin
            if (!mask8[i]) begin
                lanes[8*i +: 8] = 8'h00;
            end
        end
        mask0  = mask8[3:0];
        mask1  = mask8[7:4];
        wdata0 = lanes[31:0];
        wdata1 = lanes[63:32];

        merged = 32'({word1, word0} >> shamt);
        case (funct3)
            F3_B:    rdata = {{24{merged[7]}}, merged[7:0]};
            F3_H:    rdata = {{16{merged[15]}}, merged[15:0]};
            F3_BU:   rdata = {24'h0, merged[7:0]};
            F3_HU:   rdata = {16'h0, merged[15:0]};
            default: rdata = merged;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, word-aligned memory strobes, split or faulted misaligned
// accesses, fixed read latency, and a valid/ready response carrying extended load data.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int READ_LATENCY  = 1,
    parameter bit MISALIGN_MODE = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_fault,
    output logic        data_read,
    output logic [3:0]  data_write,
    output logic [31:0] data_addr,
    output logic [31:0] data_in,
    input  logic [31:0] data_out,
    output logic [2:0]  dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // resp_valid and its payload stay constant until that edge.

    localparam int CW = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);
    localparam logic [CW-1:0] LAT = CW'(READ_LATENCY);

    state_t        state, next;
    logic          r_is_store;
    logic [2:0]    r_funct3;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic          r_split;
    logic [1:0]    r_fault;
    logic [31:0]   word0, word1;
    logic [CW-1:0] cnt;

    logic [1:0]  fault_in;
    logic        split_in;
    logic        misal_in;
    logic        cross_in;
    logic [31:0] word_base;
    logic [3:0]  mask0, mask1;
    logic [31:0] wdata0, wdata1, align_rdata;

    always_comb begin
        misal_in = (req_funct3[1:0] == 2'b01 && req_addr[0])
                || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
        cross_in = (req_funct3[1:0] == 2'b01 && req_addr[1:0] == 2'b11)
                || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
        if (!funct3_legal(req_is_store, req_funct3)) begin
            fault_in = FAULT_FUNCT3;
        end else if (MISALIGN_MODE && misal_in) begin
            fault_in = FAULT_MISALIGN;
        end else begin
            fault_in = FAULT_NONE;
        end
        split_in = !MISALIGN_MODE && cross_in;
    end

    lsu_align u_align (
        .funct3 (r_funct3),
        .offset (r_addr[1:0]),
        .wdata  (r_wdata),
        .word0  (word0),
        .word1  (word1),
        .mask0  (mask0),
        .mask1  (mask1),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .rdata  (align_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            r_is_store <= 1'b0;
            r_funct3   <= 3'b000;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_split    <= 1'b0;
            r_fault    <= FAULT_NONE;
            word0      <= 32'h0;
            word1      <= 32'h0;
            cnt        <= '0;
        end else begin
            state <= next;
            if (state == S_IDLE && req_valid) begin
                r_is_store <= req_is_store;
                r_funct3   <= req_funct3;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_split    <= split_in;
                r_fault    <= fault_in;
            end
            // cnt counts cycles since the read strobe; data_out is sampled when it reaches LAT.
            case (state)
                S_ACC0, S_ACC1:   cnt <= CW'(1);
                S_WAIT0, S_WAIT1: cnt <= cnt + CW'(1);
                default:          cnt <= cnt;
            endcase
            if (state == S_WAIT0 && cnt == LAT) begin
                word0 <= data_out;
            end
            if (state == S_WAIT1 && cnt == LAT) begin
                word1 <= data_out;
            end
        end
    end

    always_comb begin
        next       = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        data_read  = 1'b0;
        data_write = 4'b0000;
        data_addr  = 32'h0;
        data_in    = 32'h0;
        word_base  = {r_addr[31:2], 2'b00};
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    next = (fault_in != FAULT_NONE) ? S_RESP : S_ACC0;
                end
            end
            S_ACC0: begin
                data_addr = word_base;
                if (r_is_store) begin
                    data_write = mask0;
                    data_in    = wdata0;
                    next       = r_split ? S_ACC1 : S_RESP;
                end else begin
                    data_read = 1'b1;
                    next      = S_WAIT0;
                end
            end
            S_WAIT0: begin
                if (cnt == LAT) begin
                    next = r_split ? S_ACC1 : S_RESP;
                end
            end
            S_ACC1: begin
                data_addr = word_base + 32'd4;
                if (r_is_store) begin
                    data_write = mask1;
                    data_in    = wdata1;
                    next       = S_RESP;
                end else begin
                    data_read = 1'b1;
                    next      = S_WAIT1;
                end
            end
            S_WAIT1: begin
                if (cnt == LAT) begin
                    next = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    next = S_IDLE;
                end
            end
            default: next = S_IDLE;
        endcase
    end

    assign resp_rdata = (state == S_RESP && !r_is_store && r_fault == FAULT_NONE) ? align_rdata : 32'h0;
    assign resp_fault = (state == S_RESP) ? r_fault : FAULT_NONE;
    assign dbg_state  = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: split-mode unit with 3-cycle reads, plus a fault-mode unit with 1-cycle reads.
module tb_load_store_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem [0:1023];

    logic        a_req_valid, a_req_ready, a_req_is_store, a_resp_valid, a_resp_ready, a_data_read;
    logic [2:0]  a_req_funct3, a_dbg_state;
    logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata, a_data_addr, a_data_in, a_data_out;
    logic [1:0]  a_resp_fault;
    logic [3:0]  a_data_write;
    logic [31:0] a_pipe [0:2];

    logic        b_req_valid, b_req_ready, b_req_is_store, b_resp_valid, b_resp_ready, b_data_read;
    logic [2:0]  b_req_funct3, b_dbg_state;
    logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata, b_data_addr, b_data_in, b_data_out;
    logic [1:0]  b_resp_fault;
    logic [3:0]  b_data_write;
    logic [31:0] b_pipe;

    load_store_unit #(.READ_LATENCY(3), .MISALIGN_MODE(1'b0)) dut (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_is_store(a_req_is_store),
        .req_funct3(a_req_funct3), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_rdata(a_resp_rdata),
        .resp_fault(a_resp_fault), .data_read(a_data_read), .data_write(a_data_write),
        .data_addr(a_data_addr), .data_in(a_data_in), .data_out(a_data_out), .dbg_state(a_dbg_state)
    );

    load_store_unit #(.READ_LATENCY(1), .MISALIGN_MODE(1'b1)) dut_fault (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_is_store(b_req_is_store),
        .req_funct3(b_req_funct3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_rdata(b_resp_rdata),
        .resp_fault(b_resp_fault), .data_read(b_data_read), .data_write(b_data_write),
        .data_addr(b_data_addr), .data_in(b_data_in), .data_out(b_data_out), .dbg_state(b_dbg_state)
    );

    // Memory answers exactly READ_LATENCY cycles after the strobe; other cycles carry junk.
    always @(posedge clk) begin
        a_pipe[0] <= a_data_read ? mem[a_data_addr[11:2]] : 32'hBAD0BAD0;
        a_pipe[1] <= a_pipe[0];
        a_pipe[2] <= a_pipe[1];
        b_pipe    <= b_data_read ? mem[b_data_addr[11:2]] : 32'hBAD1BAD1;
    end
    assign a_data_out = a_pipe[2];
    assign b_data_out = b_pipe;

    int          wr_cyc_q[$];
    logic [31:0] wr_addr_q[$];
    logic [3:0]  wr_mask_q[$];
    logic [31:0] wr_data_q[$];
    int          rd_cyc_q[$];
    logic [31:0] rd_addr_q[$];
    int          b_rd_n = 0;
    int          b_wr_n = 0;
    int          overlap_n = 0;

    always @(negedge clk) begin
        if (a_data_write != 4'b0000) begin
            wr_cyc_q.push_back(cyc);
            wr_addr_q.push_back(a_data_addr);
            wr_mask_q.push_back(a_data_write);
            wr_data_q.push_back(a_data_in);
        end
        if (a_data_read) begin
            rd_cyc_q.push_back(cyc);
            rd_addr_q.push_back(a_data_addr);
        end
        if (b_data_read) b_rd_n++;
        if (b_data_write != 4'b0000) b_wr_n++;
        if ((a_data_read && a_data_write != 4'b0000) || (b_data_read && b_data_write != 4'b0000))
            overlap_n++;
    end

    int t_acc, t_resp;

    task automatic send_a(input logic st, input logic [2:0] f3, input logic [31:0] ad, input logic [31:0] wd);
        int n = 0;
        a_req_valid = 1'b1; a_req_is_store = st; a_req_funct3 = f3; a_req_addr = ad; a_req_wdata = wd;
        while (a_req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (n >= 20) begin failures++; $display("FAIL send_a_timeout addr=%h", ad); end
        t_acc = cyc;
        @(negedge clk);
        a_req_valid = 1'b0;
    endtask

    task automatic wait_a();
        int n = 0;
        while (a_resp_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (n >= 40) begin failures++; $display("FAIL wait_a_timeout state=%0d", a_dbg_state); end
        t_resp = cyc;
    endtask

    task automatic release_a();
        a_resp_ready = 1'b1;
        @(negedge clk);
        a_resp_ready = 1'b0;
    endtask

    task automatic send_b(input logic [2:0] f3, input logic [31:0] ad);
        int n = 0;
        b_req_valid = 1'b1; b_req_is_store = 1'b0; b_req_funct3 = f3; b_req_addr = ad; b_req_wdata = 32'h0;
        while (b_req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        t_acc = cyc;
        @(negedge clk);
        b_req_valid = 1'b0;
        n = 0;
        while (b_resp_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (n >= 40) begin failures++; $display("FAIL b_timeout addr=%h", ad); end
        t_resp = cyc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_req_ready, a_resp_valid, a_data_read, a_data_write, a_dbg_state} !== {1'b1, 1'b0, 1'b0, 4'h0, 3'd0}) begin
            failures++;
            $display("FAIL reset_ctrl got ready=%b valid=%b rd=%b wr=%b st=%0d want 1 0 0 0000 0",
                     a_req_ready, a_resp_valid, a_data_read, a_data_write, a_dbg_state);
        end
        checks++;
        if ({a_data_addr, a_data_in, a_resp_rdata, a_resp_fault} !== 98'h0) begin
            failures++;
            $display("FAIL reset_data got addr=%h in=%h rdata=%h fault=%b want zeros",
                     a_data_addr, a_data_in, a_resp_rdata, a_resp_fault);
        end
        checks++;
        if (b_req_ready !== 1'b1 || b_resp_valid !== 1'b0) begin
            failures++; $display("FAIL reset_b got ready=%b valid=%b want 1 0", b_req_ready, b_resp_valid);
        end
    endtask

    task automatic test_store_aligned();
        logic [2:0]  f3s [4] = '{3'b010, 3'b000, 3'b001, 3'b000};
        logic [31:0] ads [4] = '{32'h100, 32'h103, 32'h102, 32'h101};
        logic [31:0] wds [4] = '{32'hDEADBEEF, 32'h123456AB, 32'h1234BEEF, 32'hFFFFFFFF};
        logic [3:0]  msk [4] = '{4'b1111, 4'b1000, 4'b1100, 4'b0010};
        logic [31:0] dat [4] = '{32'hDEADBEEF, 32'hAB000000, 32'hBEEF0000, 32'h0000FF00};
        for (int i = 0; i < 4; i++) begin
            int wb = wr_addr_q.size();
            send_a(1'b1, f3s[i], ads[i], wds[i]);
            wait_a();
            checks++;
            if (t_resp - t_acc !== 2 || a_resp_fault !== 2'b00 || a_resp_rdata !== 32'h0) begin
                failures++;
                $display("FAIL store%0d_resp got lat=%0d fault=%b rdata=%h want 2 00 0",
                         i, t_resp - t_acc, a_resp_fault, a_resp_rdata);
            end
            checks++;
            if (wr_addr_q.size() - wb !== 1) begin
                failures++; $display("FAIL store%0d_count got %0d want 1", i, wr_addr_q.size() - wb);
            end else if (wr_cyc_q[wb] - t_acc !== 1 || wr_addr_q[wb] !== 32'h100 ||
                         wr_mask_q[wb] !== msk[i] || wr_data_q[wb] !== dat[i]) begin
                failures++;
                $display("FAIL store%0d_write got dt=%0d addr=%h mask=%b data=%h want 1 00000100 %b %h",
                         i, wr_cyc_q[wb] - t_acc, wr_addr_q[wb], wr_mask_q[wb], wr_data_q[wb], msk[i], dat[i]);
            end
            release_a();
        end
    endtask

    task automatic test_load_aligned();
        logic [2:0]  f3s [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001, 3'b010};
        logic [31:0] ads [6] = '{32'h101, 32'h101, 32'h100, 32'h100, 32'h102, 32'h100};
        logic [31:0] exp [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8000, 32'h00008000, 32'h0, 32'h00008000};
        mem[10'h40] = 32'h00008000;
        for (int i = 0; i < 6; i++) begin
            int rb = rd_addr_q.size();
            send_a(1'b0, f3s[i], ads[i], 32'h0);
            wait_a();
            checks++;
            if (t_resp - t_acc !== 5 || a_resp_rdata !== exp[i] || a_resp_fault !== 2'b00) begin
                failures++;
                $display("FAIL load%0d got lat=%0d rdata=%h fault=%b want 5 %h 00",
                         i, t_resp - t_acc, a_resp_rdata, a_resp_fault, exp[i]);
            end
            checks++;
            if (rd_addr_q.size() - rb !== 1) begin
                failures++; $display("FAIL load%0d_reads got %0d want 1", i, rd_addr_q.size() - rb);
            end else if (rd_cyc_q[rb] - t_acc !== 1 || rd_addr_q[rb] !== 32'h100) begin
                failures++;
                $display("FAIL load%0d_strobe got dt=%0d addr=%h want 1 00000100", i, rd_cyc_q[rb] - t_acc, rd_addr_q[rb]);
            end
            release_a();
        end
    endtask

    task automatic test_load_split();
        logic [2:0]  f3s [7] = '{3'b010, 3'b001, 3'b001, 3'b101, 3'b001, 3'b000, 3'b010};
        logic [31:0] ads [7] = '{32'h0FE, 32'h0FF, 32'h103, 32'h103, 32'h101, 32'h0FF, 32'hFFFFFFFE};
        logic [31:0] exp [7] = '{32'h66554433, 32'h00005544, 32'hFFFFF088, 32'h0000F088,
                                 32'h00007766, 32'h00000044, 32'h66554433};
        logic [31:0] ad0 [7] = '{32'h0FC, 32'h0FC, 32'h100, 32'h100, 32'h100, 32'h0FC, 32'hFFFFFFFC};
        logic [31:0] ad1 [7] = '{32'h100, 32'h100, 32'h104, 32'h104, 32'h0, 32'h0, 32'h0};
        int          nrd [7] = '{2, 2, 2, 2, 1, 1, 2};
        mem[10'h3F] = 32'h44332211; mem[10'h40] = 32'h88776655; mem[10'h41] = 32'h000000F0;
        mem[10'h3FF] = 32'h44332211; mem[10'h000] = 32'h88776655;
        for (int i = 0; i < 7; i++) begin
            int rb = rd_addr_q.size();
            int lat = (nrd[i] == 2) ? 9 : 5;
            send_a(1'b0, f3s[i], ads[i], 32'h0);
            wait_a();
            checks++;
            if (t_resp - t_acc !== lat || a_resp_rdata !== exp[i] || a_resp_fault !== 2'b00) begin
                failures++;
                $display("FAIL split_load%0d got lat=%0d rdata=%h fault=%b want %0d %h 00",
                         i, t_resp - t_acc, a_resp_rdata, a_resp_fault, lat, exp[i]);
            end
            checks++;
            if (rd_addr_q.size() - rb !== nrd[i]) begin
                failures++; $display("FAIL split_load%0d_reads got %0d want %0d", i, rd_addr_q.size() - rb, nrd[i]);
            end else if (rd_addr_q[rb] !== ad0[i] || rd_cyc_q[rb] - t_acc !== 1 ||
                         (nrd[i] == 2 && (rd_addr_q[rb+1] !== ad1[i] || rd_cyc_q[rb+1] - t_acc !== 5))) begin
                failures++;
                $display("FAIL split_load%0d_strobes got first=%h dt=%0d want %h 1 (second want %h dt 5)",
                         i, rd_addr_q[rb], rd_cyc_q[rb] - t_acc, ad0[i], ad1[i]);
            end
            release_a();
        end
    endtask

    task automatic test_store_split();
        logic [2:0]  f3s [2] = '{3'b010, 3'b001};
        logic [31:0] ads [2] = '{32'h1FD, 32'h2FF};
        logic [31:0] wds [2] = '{32'hAABBCCDD, 32'h0000BEEF};
        logic [31:0] exp_q[$];
        exp_q = '{32'h1FC, 32'hE, 32'hBBCCDD00, 32'h200, 32'h1, 32'h000000AA,
                  32'h2FC, 32'h8, 32'hEF000000, 32'h300, 32'h1, 32'h000000BE};
        for (int i = 0; i < 2; i++) begin
            int wb = wr_addr_q.size();
            send_a(1'b1, f3s[i], ads[i], wds[i]);
            wait_a();
            checks++;
            if (t_resp - t_acc !== 3 || a_resp_fault !== 2'b00) begin
                failures++; $display("FAIL split_store%0d_resp got lat=%0d fault=%b want 3 00", i, t_resp - t_acc, a_resp_fault);
            end
            checks++;
            if (wr_addr_q.size() - wb !== 2) begin
                failures++; $display("FAIL split_store%0d_count got %0d want 2", i, wr_addr_q.size() - wb);
                repeat (6) void'(exp_q.pop_front());
            end else begin
                for (int k = 0; k < 2; k++) begin
                    logic [31:0] ea, em, ed;
                    ea = exp_q.pop_front(); em = exp_q.pop_front(); ed = exp_q.pop_front();
                    checks++;
                    if (wr_addr_q[wb+k] !== ea || wr_mask_q[wb+k] !== em[3:0] || wr_data_q[wb+k] !== ed ||
                        wr_cyc_q[wb+k] - t_acc !== k + 1) begin
                        failures++;
                        $display("FAIL split_store%0d_part%0d got addr=%h mask=%b data=%h dt=%0d want %h %b %h %0d",
                                 i, k, wr_addr_q[wb+k], wr_mask_q[wb+k], wr_data_q[wb+k], wr_cyc_q[wb+k] - t_acc,
                                 ea, em[3:0], ed, k + 1);
                    end
                end
            end
            release_a();
        end
    endtask

    task automatic test_illegal();
        int wb = wr_addr_q.size();
        int rb = rd_addr_q.size();
        send_a(1'b0, 3'b011, 32'h100, 32'h0);
        wait_a();
        checks++;
        if (t_resp - t_acc !== 1 || a_resp_fault !== 2'b10 || a_resp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL illegal_load got lat=%0d fault=%b rdata=%h want 1 10 0", t_resp - t_acc, a_resp_fault, a_resp_rdata);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (a_resp_valid !== 1'b1 || a_resp_fault !== 2'b10 || a_resp_rdata !== 32'h0 || a_req_ready !== 1'b0) begin
                failures++;
                $display("FAIL illegal_hold%0d got valid=%b fault=%b rdata=%h ready=%b want 1 10 0 0",
                         k, a_resp_valid, a_resp_fault, a_resp_rdata, a_req_ready);
            end
        end
        release_a();
        send_a(1'b1, 3'b100, 32'h100, 32'h12345678);
        wait_a();
        checks++;
        if (a_resp_fault !== 2'b10 || t_resp - t_acc !== 1) begin
            failures++; $display("FAIL illegal_store got fault=%b lat=%0d want 10 1", a_resp_fault, t_resp - t_acc);
        end
        release_a();
        checks++;
        if (wr_addr_q.size() != wb || rd_addr_q.size() != rb) begin
            failures++;
            $display("FAIL illegal_strobes got writes=%0d reads=%0d want 0 0", wr_addr_q.size() - wb, rd_addr_q.size() - rb);
        end
    endtask

    task automatic test_misalign_fault();
        logic [2:0]  f3s [3] = '{3'b010, 3'b001, 3'b010};
        logic [31:0] ads [3] = '{32'h0FE, 32'h101, 32'h100};
        logic [1:0]  flt [3] = '{2'b01, 2'b01, 2'b00};
        logic [31:0] exp [3] = '{32'h0, 32'h0, 32'h88776655};
        int          lat [3] = '{1, 1, 3};
        int          nrd [3] = '{0, 0, 1};
        mem[10'h3F] = 32'h44332211; mem[10'h40] = 32'h88776655;
        for (int i = 0; i < 3; i++) begin
            int rb = b_rd_n;
            send_b(f3s[i], ads[i]);
            checks++;
            if (b_resp_fault !== flt[i] || b_resp_rdata !== exp[i] || t_resp - t_acc !== lat[i] || b_rd_n - rb !== nrd[i]) begin
                failures++;
                $display("FAIL misalign%0d got fault=%b rdata=%h lat=%0d reads=%0d want %b %h %0d %0d",
                         i, b_resp_fault, b_resp_rdata, t_resp - t_acc, b_rd_n - rb, flt[i], exp[i], lat[i], nrd[i]);
            end
            b_resp_ready = 1'b1;
            @(negedge clk);
            b_resp_ready = 1'b0;
        end
    endtask

    task automatic test_reset_abort();
        int wb = wr_addr_q.size();
        int seen_valid = 0;
        send_a(1'b1, 3'b010, 32'h1FD, 32'hAABBCCDD);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (a_dbg_state !== 3'd0 || a_data_write !== 4'h0 || a_data_addr !== 32'h0 || a_data_in !== 32'h0) begin
            failures++;
            $display("FAIL abort_outputs got st=%0d wr=%b addr=%h in=%h want 0 0000 0 0",
                     a_dbg_state, a_data_write, a_data_addr, a_data_in);
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (a_resp_valid) seen_valid++;
        end
        checks++;
        if (wr_addr_q.size() - wb !== 1 || seen_valid !== 0) begin
            failures++;
            $display("FAIL abort_writes got writes=%0d resp=%0d want 1 0", wr_addr_q.size() - wb, seen_valid);
        end else if (wr_addr_q[wb] !== 32'h1FC) begin
            failures++; $display("FAIL abort_first got addr=%h want 000001fc", wr_addr_q[wb]);
        end
    endtask

    task automatic test_back_to_back();
        int t_rel;
        mem[10'h60] = 32'hCAFEF00D;
        send_a(1'b1, 3'b010, 32'h180, 32'h11223344);
        wait_a();
        checks++;
        if (a_req_ready !== 1'b0) begin
            failures++; $display("FAIL b2b_busy got ready=%b want 0", a_req_ready);
        end
        release_a();
        t_rel = cyc;
        checks++;
        if (a_req_ready !== 1'b1) begin
            failures++; $display("FAIL b2b_ready got ready=%b want 1", a_req_ready);
        end
        send_a(1'b0, 3'b010, 32'h180, 32'h0);
        wait_a();
        checks++;
        if (t_acc !== t_rel || a_resp_rdata !== 32'hCAFEF00D || t_resp - t_acc !== 5) begin
            failures++;
            $display("FAIL b2b_load got acc_dt=%0d rdata=%h lat=%0d want 0 cafef00d 5",
                     t_acc - t_rel, a_resp_rdata, t_resp - t_acc);
        end
        release_a();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        a_req_valid = 1'b0; a_req_is_store = 1'b0; a_req_funct3 = 3'b000; a_req_addr = 32'h0; a_req_wdata = 32'h0;
        a_resp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_is_store = 1'b0; b_req_funct3 = 3'b000; b_req_addr = 32'h0; b_req_wdata = 32'h0;
        b_resp_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_store_aligned();
        test_load_aligned();
        test_load_split();
        test_store_split();
        test_illegal();
        test_misalign_fault();
        test_reset_abort();
        test_back_to_back();
        checks++;
        if (overlap_n !== 0 || b_wr_n !== 0) begin
            failures++; $display("FAIL strobe_overlap got overlap=%0d b_writes=%0d want 0 0", overlap_n, b_wr_n);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
